child_fanout_dispatcher: RTL and testbench

//  Stage directly upstream of a five-child generated hierarchy node: accepts one valid/ready

---
 rtl/child_fanout_pkg.sv | 21 ++
 rtl/child_rr_timer.sv | 50 +++++
 rtl/child_fanout_dispatcher.sv | 118 +++++++++++
 tb/tb_child_fanout_dispatcher.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/child_fanout_pkg.sv
// Shared types and defaults for the child fan-out dispatcher.
//   state_t    : dispatcher holding state (EMPTY / HOLD)
//   ptr_width  : width of the target-child index for a given child count
package child_fanout_pkg;

    typedef enum logic {
        EMPTY = 1'b0,
        HOLD  = 1'b1
    } state_t;

    localparam int unsigned DEF_DATA_W       = 32;
    localparam int unsigned DEF_NUM_CHILDREN = 5;
    localparam int unsigned DEF_SKIP_CYCLES  = 16;
    localparam int unsigned DEF_CNT_W        = 16;

    // Index width for n children; never below one bit.
    function automatic int unsigned ptr_width(input int unsigned n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/child_rr_timer.sv
// Round-robin target pointer with stall timeout.
//   clk, rst_n : clock, async active-low reset
//   deliver    : held item accepted by the target child this cycle
//   stall      : item held but target child not ready this cycle
//   ptr        : current target child index (registered)
//   skip_c     : stall timeout expires this cycle; ptr advances on the next edge
module child_rr_timer
    import child_fanout_pkg::*;
#(
    parameter int unsigned NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter int unsigned SKIP_CYCLES  = DEF_SKIP_CYCLES
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 deliver,
    input  logic                                 stall,
    output logic [ptr_width(NUM_CHILDREN)-1:0]   ptr,
    output logic                                 skip_c
);

    localparam int unsigned PTR_W  = ptr_width(NUM_CHILDREN);
    localparam int unsigned WAIT_W = $clog2(SKIP_CYCLES + 1);

    localparam logic [PTR_W-1:0]  PTR_LAST  = PTR_W'(NUM_CHILDREN - 1);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(SKIP_CYCLES - 1);

    logic [WAIT_W-1:0] wait_cnt;
    logic              advance_c;

    assign skip_c    = stall && (wait_cnt == WAIT_LAST);
    assign advance_c = deliver || skip_c;

    // Pointer wraps explicitly so non-power-of-two counts never reach NUM_CHILDREN.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr      <= '0;
            wait_cnt <= '0;
        end else begin
            if (advance_c) begin
                ptr <= (ptr == PTR_LAST) ? '0 : ptr + PTR_W'(1);
            end
            if (advance_c || !stall) begin
                wait_cnt <= '0;
            end else begin
                wait_cnt <= wait_cnt + WAIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/child_fanout_dispatcher.sv
// One-entry valid/ready stage that deals items round-robin to NUM_CHILDREN
// child channels, skipping a child that stalls for SKIP_CYCLES cycles.
//   clk, rst_n          : clock, async active-low reset
//   in_valid/in_data    : upstream stream
//   in_ready            : holding register can accept (combinational pass-through)
//   out_valid           : one-hot per-child valid
//   out_data            : payload shared by all children
//   out_ready           : per-child ready (only the target's bit matters)
//   ptr                 : current target child
//   sent_cnt, skip_cnt  : delivered items (wraps), timeout skips (saturates)
module child_fanout_dispatcher
    import child_fanout_pkg::*;
#(
    parameter int unsigned DATA_W       = DEF_DATA_W,
    parameter int unsigned NUM_CHILDREN = DEF_NUM_CHILDREN,
    parameter int unsigned SKIP_CYCLES  = DEF_SKIP_CYCLES,
    parameter int unsigned CNT_W        = DEF_CNT_W
) (
    input  logic                                 clk,
    input  logic                                 rst_n,
    input  logic                                 in_valid,
    input  logic [DATA_W-1:0]                    in_data,
    output logic                                 in_ready,
    output logic [NUM_CHILDREN-1:0]              out_valid,
    output logic [DATA_W-1:0]                    out_data,
    input  logic [NUM_CHILDREN-1:0]              out_ready,
    output logic [ptr_width(NUM_CHILDREN)-1:0]   ptr,
    output logic [CNT_W-1:0]                     sent_cnt,
    output logic [CNT_W-1:0]                     skip_cnt
);

    localparam int unsigned PTR_W = ptr_width(NUM_CHILDREN);

    state_t                  state;
    state_t                  state_nxt;
    logic [DATA_W-1:0]       data_q;
    logic [NUM_CHILDREN-1:0] tgt_onehot_c;
    logic                    tgt_ready_c;
    logic                    deliver_c;
    logic                    stall_c;
    logic                    capture_c;
    logic                    skip_c;

    child_rr_timer #(
        .NUM_CHILDREN (NUM_CHILDREN),
        .SKIP_CYCLES  (SKIP_CYCLES)
    ) u_timer (
        .clk     (clk),
        .rst_n   (rst_n),
        .deliver (deliver_c),
        .stall   (stall_c),
        .ptr     (ptr),
        .skip_c  (skip_c)
    );

    // One-hot decode of the target child and its ready bit.
    always_comb begin
        tgt_onehot_c = '0;
        for (int unsigned i = 0; i < NUM_CHILDREN; i++) begin
            tgt_onehot_c[i] = (ptr == PTR_W'(i));
        end
        tgt_ready_c = |(tgt_onehot_c & out_ready);
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= EMPTY;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state: delivery with a concurrent capture keeps HOLD (pass-through).
    always_comb begin
        state_nxt = state;
        case (state)
            EMPTY:   if (in_valid) state_nxt = HOLD;
            HOLD:    if (tgt_ready_c && !in_valid) state_nxt = EMPTY;
            default: state_nxt = EMPTY;
        endcase
    end

    // Outputs and handshake qualifiers.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = '0;
        deliver_c = 1'b0;
        stall_c   = 1'b0;
        case (state)
            EMPTY: in_ready = 1'b1;
            HOLD: begin
                in_ready  = tgt_ready_c;
                out_valid = tgt_onehot_c;
                deliver_c = tgt_ready_c;
                stall_c   = !tgt_ready_c;
            end
            default: ;
        endcase
        capture_c = in_valid && in_ready;
    end

    // Payload register and debug counters.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_q   <= '0;
            sent_cnt <= '0;
            skip_cnt <= '0;
        end else begin
            if (capture_c) data_q <= in_data;
            if (deliver_c) sent_cnt <= sent_cnt + CNT_W'(1);
            if (skip_c && (skip_cnt != '1)) skip_cnt <= skip_cnt + CNT_W'(1);
        end
    end

    assign out_data = data_q;

endmodule

// File: tb/tb_child_fanout_dispatcher.sv
// Randomised bench for child_fanout_dispatcher with an in-bench behavioural
// model, an in-order scoreboard, and a few hand-computed expectations.
module tb_child_fanout_dispatcher;

    localparam int N      = 5;
    localparam int SKIP   = 16;
    localparam int CNT_W  = 4;
    localparam int DW     = 32;
    localparam int PW     = $clog2(N);
    localparam int CNTMAX = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic [DW-1:0]    in_data = '0;
    logic             in_ready;
    logic [N-1:0]     out_valid;
    logic [DW-1:0]    out_data;
    logic [N-1:0]     out_ready = '0;
    logic [PW-1:0]    ptr;
    logic [CNT_W-1:0] sent_cnt;
    logic [CNT_W-1:0] skip_cnt;

    child_fanout_dispatcher #(
        .DATA_W       (DW),
        .NUM_CHILDREN (N),
        .SKIP_CYCLES  (SKIP),
        .CNT_W        (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .ptr       (ptr),
        .sent_cnt  (sent_cnt),
        .skip_cnt  (skip_cnt)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Behavioural model: is an item held, which one, who is targeted, how long waited.
    bit            m_full = 1'b0;
    logic [DW-1:0] m_data = '0;
    int            m_ptr = 0;
    int            m_wait = 0;
    int            m_sent = 0;
    int            m_skip = 0;
    logic [DW-1:0] sb[$];

    bit last_acc = 1'b0;
    int shown2 = 0;
    bit tog = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Compare DUT to model at the falling edge, then advance model across the next rising edge.
    task automatic compare_step();
        logic [N-1:0]  ev;
        logic [DW-1:0] front;
        if (!rst_n) begin
            m_full = 1'b0; m_data = '0; m_ptr = 0; m_wait = 0; m_sent = 0; m_skip = 0;
            sb.delete();
            last_acc = 1'b0;
            check("rst_out_valid", 64'(out_valid), 64'(0));
            check("rst_ptr",       64'(ptr),       64'(0));
            check("rst_sent",      64'(sent_cnt),  64'(0));
            check("rst_skip",      64'(skip_cnt),  64'(0));
            check("rst_out_data",  64'(out_data),  64'(0));
            check("rst_in_ready",  64'(in_ready),  64'(1));
            return;
        end
        ev = '0;
        if (m_full) ev[m_ptr] = 1'b1;
        check("out_valid", 64'(out_valid), 64'(ev));
        check("in_ready",  64'(in_ready),  64'(!m_full || out_ready[m_ptr]));
        check("ptr",       64'(ptr),       64'(m_ptr));
        check("sent_cnt",  64'(sent_cnt),  64'(m_sent));
        check("skip_cnt",  64'(skip_cnt),  64'(m_skip));
        if (m_full) check("out_data", 64'(out_data), 64'(m_data));
        if ((out_valid & out_ready) != '0) begin
            if (sb.size() == 0) begin
                check("sb_underflow", 64'(1), 64'(0));
            end else begin
                front = sb.pop_front();
                check("sb_order", 64'(out_data), 64'(front));
            end
        end
        last_acc = in_valid && in_ready;
        if (out_valid[2]) shown2++;
        // Advance model over the coming rising edge.
        if (!m_full) begin
            if (in_valid) begin
                m_full = 1'b1; m_data = in_data; m_wait = 0; sb.push_back(in_data);
            end
        end else if (out_ready[m_ptr]) begin
            m_sent = (m_sent + 1) % (1 << CNT_W);
            m_ptr  = (m_ptr + 1) % N;
            m_wait = 0;
            if (in_valid) begin
                m_data = in_data; sb.push_back(in_data);
            end else begin
                m_full = 1'b0;
            end
        end else begin
            m_wait++;
            if (m_wait == SKIP) begin
                m_ptr  = (m_ptr + 1) % N;
                m_skip = (m_skip < CNTMAX) ? m_skip + 1 : CNTMAX;
                m_wait = 0;
            end
        end
    endtask

    task automatic tick();
        @(negedge clk);
        compare_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_ready(input int mode, input logic [N-1:0] mask);
        case (mode)
            0: out_ready = '1;
            1: out_ready = mask;
            2: begin out_ready = tog ? '1 : '0; tog = !tog; end
            3: out_ready = N'($urandom);
            default: out_ready = ($urandom_range(0, 7) == 0) ? N'($urandom) : '0;
        endcase
    endtask

    task automatic drive(input int n, input int mode, input logic [N-1:0] mask);
        int k = 0;
        for (int c = 0; c < 3000 && k < n; c++) begin
            in_valid = (mode == 3) ? 1'($urandom_range(0, 1)) : 1'b1;
            in_data  = $urandom;
            set_ready(mode, mask);
            tick();
            if (last_acc) k++;
        end
        check("drive_accept_count", 64'(k), 64'(n));
        in_valid = 1'b0;
    endtask

    task automatic drain(input int cycles, input int mode, input logic [N-1:0] mask);
        in_valid = 1'b0;
        for (int c = 0; c < cycles; c++) begin
            set_ready(mode, mask);
            tick();
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    initial begin
        do_reset();

        // Back-to-back with every child ready: 10 items in 11 edges.
        out_ready = '1;
        for (int i = 0; i < 10; i++) begin
            in_valid = 1'b1;
            in_data  = 32'(100 + i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        check("t1_sent_10", 64'(sent_cnt), 64'(10));
        check("t1_ptr_wrap", 64'(ptr), 64'(0));

        // Child 2 dead: shown the item 16 cycles, then skipped to child 3.
        do_reset();
        shown2 = 0;
        drive(5, 1, 5'b11011);
        drain(3, 1, 5'b11011);
        check("t2_shown2_16", 64'(shown2), 64'(16));
        check("t2_skip_1", 64'(skip_cnt), 64'(1));
        check("t2_sent_5", 64'(sent_cnt), 64'(5));

        // Target ready every other cycle: never times out.
        do_reset();
        tog = 1'b0;
        drive(20, 2, '0);
        drain(4, 2, '0);
        check("t3_skip_0", 64'(skip_cnt), 64'(0));
        check("t3_sent_20_mod16", 64'(sent_cnt), 64'(4));

        // Everyone stalled: 200 edges -> 12 skips, ptr 12 mod 5 = 2; then saturate.
        do_reset();
        out_ready = '0;
        in_valid = 1'b1;
        in_data = 32'hCAFE_0001;
        tick();
        in_valid = 1'b0;
        drain(200, 1, '0);
        check("t4_skip_12", 64'(skip_cnt), 64'(12));
        check("t4_ptr_2", 64'(ptr), 64'(2));
        drain(100, 1, '0);
        check("t4_skip_sat", 64'(skip_cnt), 64'(15));

        // Reset while holding: outputs clear at once, held item never delivered.
        do_reset();
        drive(3, 0, '0);
        out_ready = '0;
        in_valid = 1'b1;
        in_data = 32'hDEAD_BEEF;
        tick();
        drain(3, 1, '0);
        rst_n = 1'b0;
        #1;
        check("t5_valid_clear", 64'(out_valid), 64'(0));
        check("t5_ptr_0", 64'(ptr), 64'(0));
        check("t5_sent_0", 64'(sent_cnt), 64'(0));
        tick();
        rst_n = 1'b1;
        drain(3, 0, '0);
        check("t5_not_delivered", 64'(sent_cnt), 64'(0));

        // 17 deliveries with a 4-bit counter wrap to 1.
        do_reset();
        drive(17, 0, '0);
        drain(2, 0, '0);
        check("t6_sent_wrap", 64'(sent_cnt), 64'(1));

        // Random traffic, then mostly-dead children to exercise skips.
        do_reset();
        drive(150, 3, '0);
        drain(5, 0, '0);
        drive(40, 4, '0);
        drain(5, 0, '0);
        check("rand_sb_empty", 64'(sb.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
